// File: rtl/temp_control_fsm.sv
// Greenhouse climate controller: picks IDLE / HEATING / COOLING / FAULT from
// temperature samples against user setpoints, with hysteresis, a minimum
// dwell time per state and a stale-sensor fault timeout.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   temp_valid        1-cycle strobe, temp_data holds a new sample
//   temp_data         temperature sample, unsigned degrees
//   setpoint_low      heat-on threshold
//   setpoint_high     cool-on threshold
//   status            00 idle, 01 heating, 10 cooling, 11 fault (registered)
//   heater_on         heater enable, only in HEATING (registered)
//   cooler_on         cooler/fan enable, only in COOLING (registered)
//   config_err        1 while setpoint_low >= setpoint_high (registered)
module temp_control_fsm #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned HYST          = 2,
  parameter int unsigned MIN_DWELL_SEC = 60,
  parameter int unsigned STALE_SEC     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       temp_valid,
  input  logic [7:0] temp_data,
  input  logic [7:0] setpoint_low,
  input  logic [7:0] setpoint_high,
  output logic [1:0] status,
  output logic       heater_on,
  output logic       cooler_on,
  output logic       config_err
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned DW = (MIN_DWELL_SEC > 0) ? $clog2(MIN_DWELL_SEC + 1) : 1;
  localparam int unsigned SW = (STALE_SEC > 0) ? $clog2(STALE_SEC + 1) : 1;

  localparam logic [PW-1:0] PRESCALE_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] DWELL_MAX    = DW'(MIN_DWELL_SEC);
  localparam logic [SW-1:0] STALE_MAX    = SW'(STALE_SEC);
  localparam logic [7:0]    HYST_8       = 8'(HYST);
  localparam logic [8:0]    HYST_9       = 9'(HYST);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_HEATING = 2'b01,
    ST_COOLING = 2'b10,
    ST_FAULT   = 2'b11
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] prescaler;
  logic          sec_tick;
  logic [DW-1:0] dwell_cnt;
  logic [SW-1:0] stale_cnt;
  logic [7:0]    sample;
  logic          sample_ok;
  logic          dwell_ok;
  logic          stale_hit;
  logic [8:0]    heat_off;
  logic [7:0]    cool_off;

  assign sec_tick  = (prescaler == PRESCALE_MAX);
  assign dwell_ok  = (dwell_cnt == DWELL_MAX);
  assign stale_hit = (stale_cnt == STALE_MAX);

  // Release thresholds: heat_off kept 9 bits wide so it cannot wrap,
  // cool_off clamps at zero instead of wrapping.
  always_comb begin
    heat_off = {1'b0, setpoint_low} + HYST_9;
    cool_off = (setpoint_high >= HYST_8) ? (setpoint_high - HYST_8) : 8'd0;
  end

  // One-second prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (sec_tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Sample capture and stale-sensor timer; a new sample beats the tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample    <= '0;
      sample_ok <= 1'b0;
      stale_cnt <= '0;
    end else if (temp_valid) begin
      sample    <= temp_data;
      sample_ok <= 1'b1;
      stale_cnt <= '0;
    end else if (sec_tick && !stale_hit) begin
      stale_cnt <= stale_cnt + SW'(1);
    end
  end

  // Dwell timer, restarts on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt <= '0;
    end else if (state_next != state) begin
      dwell_cnt <= '0;
    end else if (sec_tick && !dwell_ok) begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  // Setpoint sanity flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      config_err <= 1'b0;
    end else begin
      config_err <= (setpoint_low >= setpoint_high);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; HEATING and COOLING only ever exit through IDLE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (stale_hit) begin
          state_next = ST_FAULT;
        end else if (config_err || !sample_ok) begin
          state_next = ST_IDLE;
        end else if ((sample < setpoint_low) && dwell_ok) begin
          state_next = ST_HEATING;
        end else if ((sample > setpoint_high) && dwell_ok) begin
          state_next = ST_COOLING;
        end
      end
      ST_HEATING: begin
        if (stale_hit) begin
          state_next = ST_FAULT;
        end else if (config_err) begin
          state_next = ST_IDLE;
        end else if (({1'b0, sample} >= heat_off) && dwell_ok) begin
          state_next = ST_IDLE;
        end
      end
      ST_COOLING: begin
        if (stale_hit) begin
          state_next = ST_FAULT;
        end else if (config_err) begin
          state_next = ST_IDLE;
        end else if ((sample <= cool_off) && dwell_ok) begin
          state_next = ST_IDLE;
        end
      end
      ST_FAULT: begin
        // stale_hit is still set here; a fresh sample is the only way out
        if (temp_valid) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from next state so they change on the same edge as state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status    <= 2'b00;
      heater_on <= 1'b0;
      cooler_on <= 1'b0;
    end else begin
      status    <= 2'(state_next);
      heater_on <= (state_next == ST_HEATING);
      cooler_on <= (state_next == ST_COOLING);
    end
  end

endmodule

// File: tb/tb_temp_control_fsm.sv
// Directed bench for temp_control_fsm with a 4-cycle second, 2 s dwell and
// 5 s stale timeout. Every scenario starts from reset, so edge numbers in
// the comments count posedges after reset release (sec ticks on edges 4k).
module tb_temp_control_fsm;

  logic       clk;
  logic       rst;
  logic       temp_valid;
  logic [7:0] temp_data;
  logic [7:0] setpoint_low;
  logic [7:0] setpoint_high;
  logic [1:0] status;
  logic       heater_on;
  logic       cooler_on;
  logic       config_err;

  int checks = 0;
  int errors = 0;

  temp_control_fsm #(
    .TICKS_PER_SEC(4),
    .HYST(2),
    .MIN_DWELL_SEC(2),
    .STALE_SEC(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .temp_valid(temp_valid),
    .temp_data(temp_data),
    .setpoint_low(setpoint_low),
    .setpoint_high(setpoint_high),
    .status(status),
    .heater_on(heater_on),
    .cooler_on(cooler_on),
    .config_err(config_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic steps(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    temp_valid = 1'b0;
    temp_data = 8'd0;
    setpoint_low = 8'd60;
    setpoint_high = 8'd80;
    steps(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    setpoint_low = 8'd70;
    setpoint_high = 8'd70;
    rst = 1'b1;
    #2;
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL reset_status got %b want 00", status); end
    checks++; if (heater_on !== 1'b0) begin errors++; $display("FAIL reset_heater got %b want 0", heater_on); end
    checks++; if (cooler_on !== 1'b0) begin errors++; $display("FAIL reset_cooler got %b want 0", cooler_on); end
    steps(2);
    checks++; if (config_err !== 1'b0) begin errors++; $display("FAIL reset_config_err got %b want 0", config_err); end
    do_reset();
  endtask

  task automatic test_heat_cycle();
    do_reset();
    temp_data = 8'd50; temp_valid = 1'b1;
    steps(8); // e8: dwell just satisfied, no transition yet
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL heat_dwell_hold got %b want 00", status); end
    steps(1); // e9
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL heat_enter_status got %b want 01", status); end
    checks++; if ({heater_on, cooler_on} !== 2'b10) begin errors++; $display("FAIL heat_enter_enables got %b want 10", {heater_on, cooler_on}); end
    temp_data = 8'd61;
    steps(11); // e20: 61 is below heat_off=62
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL heat_hyst_hold got %b want 01", status); end
    temp_data = 8'd62;
    steps(1); // e21: sample loaded, decision lands next edge
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL heat_release_latency got %b want 01", status); end
    steps(1); // e22
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL heat_release_status got %b want 00", status); end
    checks++; if (heater_on !== 1'b0) begin errors++; $display("FAIL heat_release_heater got %b want 0", heater_on); end
  endtask

  task automatic test_cool_cycle();
    do_reset();
    temp_data = 8'd85; temp_valid = 1'b1;
    steps(9); // e9
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL cool_enter_status got %b want 10", status); end
    checks++; if ({heater_on, cooler_on} !== 2'b01) begin errors++; $display("FAIL cool_enter_enables got %b want 01", {heater_on, cooler_on}); end
    temp_data = 8'd79;
    steps(11); // e20: 79 above cool_off=78
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL cool_hyst_hold got %b want 10", status); end
    temp_data = 8'd78;
    steps(2); // e22
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL cool_release_status got %b want 00", status); end
    checks++; if (cooler_on !== 1'b0) begin errors++; $display("FAIL cool_release_cooler got %b want 0", cooler_on); end
  endtask

  task automatic test_no_direct();
    do_reset();
    temp_data = 8'd50; temp_valid = 1'b1;
    steps(9); // e9 HEATING
    temp_data = 8'd90;
    steps(7); // e16: dwell completes this edge
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL swing_heat_dwell got %b want 01", status); end
    steps(1); // e17
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL swing_via_idle got %b want 00", status); end
    steps(7); // e24
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL swing_idle_dwell got %b want 00", status); end
    steps(1); // e25
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL swing_cool_status got %b want 10", status); end
    checks++; if ({heater_on, cooler_on} !== 2'b01) begin errors++; $display("FAIL swing_cool_enables got %b want 01", {heater_on, cooler_on}); end
  endtask

  task automatic test_stale();
    do_reset();
    temp_data = 8'd65; temp_valid = 1'b1;
    steps(1); // e1
    temp_valid = 1'b0;
    steps(19); // e20: stale reaches 5
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL stale_pre got %b want 00", status); end
    steps(1); // e21
    checks++; if (status !== 2'b11) begin errors++; $display("FAIL stale_fault_status got %b want 11", status); end
    checks++; if ({heater_on, cooler_on} !== 2'b00) begin errors++; $display("FAIL stale_fault_enables got %b want 00", {heater_on, cooler_on}); end
    steps(3); // e24
    checks++; if (status !== 2'b11) begin errors++; $display("FAIL stale_fault_hold got %b want 11", status); end
    temp_valid = 1'b1;
    steps(1); // e25
    temp_valid = 1'b0;
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL stale_recover got %b want 00", status); end
  endtask

  task automatic test_config_err();
    do_reset();
    temp_data = 8'd50; temp_valid = 1'b1;
    steps(9); // e9 HEATING
    setpoint_low = 8'd70; setpoint_high = 8'd70;
    steps(1); // e10
    checks++; if (config_err !== 1'b1) begin errors++; $display("FAIL cfg_flag_set got %b want 1", config_err); end
    steps(1); // e11
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL cfg_forces_idle got %b want 00", status); end
    checks++; if (heater_on !== 1'b0) begin errors++; $display("FAIL cfg_heater_off got %b want 0", heater_on); end
    steps(19); // e30
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL cfg_idle_hold got %b want 00", status); end
    setpoint_low = 8'd60; setpoint_high = 8'd80;
    steps(1); // e31
    checks++; if (config_err !== 1'b0) begin errors++; $display("FAIL cfg_flag_clear got %b want 0", config_err); end
    steps(2); // e33
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL cfg_heat_resume got %b want 01", status); end
  endtask

  task automatic test_boundaries();
    do_reset();
    setpoint_low = 8'd0; setpoint_high = 8'd1;
    temp_data = 8'd5; temp_valid = 1'b1;
    steps(9); // e9 COOLING
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL edge_cool_enter got %b want 10", status); end
    temp_data = 8'd1;
    steps(11); // e20: cool_off clamps to 0, so 1 must not release
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL edge_cool_off_clamp got %b want 10", status); end
    rst = 1'b1;
    #1;
    checks++; if (cooler_on !== 1'b0) begin errors++; $display("FAIL edge_async_rst_cooler got %b want 0", cooler_on); end
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL edge_async_rst_status got %b want 00", status); end

    do_reset();
    setpoint_low = 8'd254; setpoint_high = 8'd255;
    temp_data = 8'd200; temp_valid = 1'b1;
    steps(9); // e9 HEATING
    temp_data = 8'd255;
    steps(15); // e24: heat_off=256 is unreachable
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL edge_heat_off_nowrap got %b want 01", status); end
    checks++; if (heater_on !== 1'b1) begin errors++; $display("FAIL edge_heat_off_heater got %b want 1", heater_on); end
    setpoint_low = 8'd255;
    steps(1);
    checks++; if (config_err !== 1'b1) begin errors++; $display("FAIL edge_cfg_255 got %b want 1", config_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    temp_valid = 1'b0;
    temp_data = 8'd0;
    setpoint_low = 8'd60;
    setpoint_high = 8'd80;
    test_reset();
    test_heat_cycle();
    test_cool_cycle();
    test_no_direct();
    test_stale();
    test_config_err();
    test_boundaries();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
